// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, 11-bit frame deframer with timeout, and a
// first-word-fall-through event FIFO. Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into event flags.
//
//   state  | meaning
//   IDLE   | bus idle, waiting for a start bit
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking stop bit and odd parity, delivering the byte
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    out_code,
  output logic                          out_break,
  output logic                          out_ext,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fall;

  state_t      state, state_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        par_bit, par_bit_n;
  logic [TW-1:0] tmr, tmr_n;
  logic        tmo;
  logic        byte_ok_n, perr_n, ferr_n;

  logic [7:0]  rx_byte;
  logic        rx_valid;

  logic        push_req, do_push, do_pop;
  logic [9:0]  push_data;
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [9:0]  head;

  // Synchronisers preset to 1 so reset looks like an idle bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmr        <= TMO_LOAD;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tmr        <= tmr_n;
      rx_valid   <= byte_ok_n;
      err_parity <= perr_n;
      err_frame  <= ferr_n;
      if (byte_ok_n) rx_byte <= shreg;
    end
  end

  // Inter-bit timer counts down from each edge; terminal count outside IDLE aborts the frame
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    tmr_n     = tmr;
    byte_ok_n = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;

    if (fall || state == IDLE) tmr_n = TMO_LOAD;
    else if (tmr != '0)        tmr_n = tmr - 1'b1;

    tmo = (state != IDLE) && !fall && (tmr == '0);

    if (tmo) begin
      ferr_n  = 1'b1;
      state_n = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            ferr_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n   = {data_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = data_s;
          state_n   = STOP;
        end
        STOP: begin
          if (!data_s)                     ferr_n    = 1'b1;
          else if (!(^{shreg, par_bit}))   perr_n    = 1'b1;
          else                             byte_ok_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_pending, brk_pending;
  logic is_e0, is_f0;

  assign is_e0     = (rx_byte == 8'hE0);
  assign is_f0     = (rx_byte == 8'hF0);
  assign push_req  = rx_valid && !is_e0 && !is_f0;
  assign push_data = {brk_pending, ext_pending, rx_byte};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else if (err_parity || err_frame) begin
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else if (rx_valid) begin
      if (is_e0)      ext_pending <= 1'b1;
      else if (is_f0) brk_pending <= 1'b1;
      else begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end
    end
  end
`else
  assign push_req  = rx_valid;
  assign push_data = {2'b00, rx_byte};
`endif

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign do_pop  = out_valid && out_ready;
  assign do_push = push_req && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != '0);
  assign fifo_count = count;
  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign out_break  = head[9];
  assign out_ext    = head[8];
  assign out_code   = head[7:0];

endmodule
